// File: rtl/qoi_pingpong_buffer_if.sv
// Bus bundle between the 6502 host side (port A), the QOI engine side
// (port B) and the ping-pong exchange buffer. The buffer uses the slave
// modport; whatever drives both ports uses the master modport.
interface qoi_pingpong_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  // Port A: host writes ingress, reads egress
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              a_cs;
  logic              a_we;
  logic              a_commit;
  logic              a_release;
  logic              a_in_ready;
  logic              a_out_valid;
  logic              a_flag_o;
  logic              a_ovf;
  // Port B: engine writes egress, reads ingress
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] b_rdata;
  logic              b_cs;
  logic              b_we;
  logic              b_commit;
  logic              b_release;
  logic              b_in_valid;
  logic              b_out_ready;
  logic              b_ovf;

  modport slave (
    input  a_addr, a_wdata, a_cs, a_we, a_commit, a_release,
    output a_rdata, a_in_ready, a_out_valid, a_flag_o, a_ovf,
    input  b_addr, b_wdata, b_cs, b_we, b_commit, b_release,
    output b_rdata, b_in_valid, b_out_ready, b_ovf
  );

  modport master (
    output a_addr, a_wdata, a_cs, a_we, a_commit, a_release,
    input  a_rdata, a_in_ready, a_out_valid, a_flag_o, a_ovf,
    output b_addr, b_wdata, b_cs, b_we, b_commit, b_release,
    input  b_rdata, b_in_valid, b_out_ready, b_ovf
  );
endinterface

// File: rtl/qoi_pingpong_buffer.sv
// Double-buffered exchange memory between the host (port A) and the QOI
// engine (port B). Each direction owns two banks handled as a two-slot
// queue: the producer fills bank wp and commits it, the consumer reads bank
// rp and releases it. Status outputs are decoded from registered state only,
// so there is no input-to-output combinational path.
module qoi_pingpong_buffer #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter bit AUTO_COMMIT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  qoi_pingpong_buffer_if.slave    bus
);
  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  // Bank storage, indexed by {bank, addr}; contents survive reset
  logic [DATA_W-1:0] in_mem  [2*DEPTH];
  logic [DATA_W-1:0] out_mem [2*DEPTH];

  // Ingress path state (host -> engine)
  logic [1:0]        in_full_q, in_full_d;
  logic              in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic              a_ovf_q, a_ovf_d, a_flag_q, a_flag_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  // Egress path state (engine -> host)
  logic [1:0]        out_full_q, out_full_d;
  logic              out_wp_q, out_wp_d, out_rp_q, out_rp_d;
  logic              b_ovf_q, b_ovf_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;

  logic in_ready_s, in_valid_s, in_acc_s, in_commit_s, in_release_s;
  logic out_ready_s, out_valid_s, out_acc_s, out_commit_s, out_release_s;

  // Ingress next-state: producer write/commit, consumer read/release
  always_comb begin
    in_ready_s   = ~in_full_q[in_wp_q];
    in_valid_s   = in_full_q[in_rp_q];
    in_acc_s     = bus.a_cs & bus.a_we & in_ready_s;
    // Explicit and auto commit in one cycle collapse into a single commit
    in_commit_s  = in_ready_s & (bus.a_commit |
                   ((AUTO_COMMIT == 1'b1) & in_acc_s & (bus.a_addr == LAST_ADDR)));
    in_release_s = bus.b_release & in_valid_s;
    in_full_d    = in_full_q;
    in_wp_d      = in_wp_q;
    in_rp_d      = in_rp_q;
    b_rdata_d    = b_rdata_q;
    if (in_commit_s) begin
      in_full_d[in_wp_q] = 1'b1;
      in_wp_d            = ~in_wp_q;
    end else begin
      in_wp_d            = in_wp_q;
    end
    // When both fire the banks differ, so the two updates never collide
    if (in_release_s) begin
      in_full_d[in_rp_q] = 1'b0;
      in_rp_d            = ~in_rp_q;
    end else begin
      in_rp_d            = in_rp_q;
    end
    if (bus.b_cs & ~bus.b_we) begin
      b_rdata_d = in_valid_s ? in_mem[{in_rp_q, bus.b_addr}] : {DATA_W{1'b0}};
    end else begin
      b_rdata_d = b_rdata_q;
    end
    a_ovf_d  = a_ovf_q | (bus.a_cs & bus.a_we & ~in_ready_s);
    a_flag_d = in_commit_s;
  end

  // Egress next-state: mirror of ingress with the ports swapped
  always_comb begin
    out_ready_s   = ~out_full_q[out_wp_q];
    out_valid_s   = out_full_q[out_rp_q];
    out_acc_s     = bus.b_cs & bus.b_we & out_ready_s;
    out_commit_s  = out_ready_s & (bus.b_commit |
                    ((AUTO_COMMIT == 1'b1) & out_acc_s & (bus.b_addr == LAST_ADDR)));
    out_release_s = bus.a_release & out_valid_s;
    out_full_d    = out_full_q;
    out_wp_d      = out_wp_q;
    out_rp_d      = out_rp_q;
    a_rdata_d     = a_rdata_q;
    if (out_commit_s) begin
      out_full_d[out_wp_q] = 1'b1;
      out_wp_d             = ~out_wp_q;
    end else begin
      out_wp_d             = out_wp_q;
    end
    if (out_release_s) begin
      out_full_d[out_rp_q] = 1'b0;
      out_rp_d             = ~out_rp_q;
    end else begin
      out_rp_d             = out_rp_q;
    end
    if (bus.a_cs & ~bus.a_we) begin
      a_rdata_d = out_valid_s ? out_mem[{out_rp_q, bus.a_addr}] : {DATA_W{1'b0}};
    end else begin
      a_rdata_d = a_rdata_q;
    end
    b_ovf_d = b_ovf_q | (bus.b_cs & bus.b_we & ~out_ready_s);
  end

  // Bank writes: only accepted producer writes land in memory
  always_ff @(posedge clk) begin
    if (in_acc_s) begin
      in_mem[{in_wp_q, bus.a_addr}] <= bus.a_wdata;
    end
    if (out_acc_s) begin
      out_mem[{out_wp_q, bus.b_addr}] <= bus.b_wdata;
    end
  end

  // Control and read-data registers; reset drops all queued banks at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_full_q  <= 2'b00;
      in_wp_q    <= 1'b0;
      in_rp_q    <= 1'b0;
      a_ovf_q    <= 1'b0;
      a_flag_q   <= 1'b0;
      b_rdata_q  <= {DATA_W{1'b0}};
      out_full_q <= 2'b00;
      out_wp_q   <= 1'b0;
      out_rp_q   <= 1'b0;
      b_ovf_q    <= 1'b0;
      a_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      in_full_q  <= in_full_d;
      in_wp_q    <= in_wp_d;
      in_rp_q    <= in_rp_d;
      a_ovf_q    <= a_ovf_d;
      a_flag_q   <= a_flag_d;
      b_rdata_q  <= b_rdata_d;
      out_full_q <= out_full_d;
      out_wp_q   <= out_wp_d;
      out_rp_q   <= out_rp_d;
      b_ovf_q    <= b_ovf_d;
      a_rdata_q  <= a_rdata_d;
    end
  end

  assign bus.a_in_ready  = ~in_full_q[in_wp_q];
  assign bus.b_in_valid  = in_full_q[in_rp_q];
  assign bus.b_out_ready = ~out_full_q[out_wp_q];
  assign bus.a_out_valid = out_full_q[out_rp_q];
  assign bus.a_flag_o    = a_flag_q;
  assign bus.a_ovf       = a_ovf_q;
  assign bus.b_ovf       = b_ovf_q;
  assign bus.a_rdata     = a_rdata_q;
  assign bus.b_rdata     = b_rdata_q;
endmodule

// File: tb/tb_qoi_pingpong_buffer.sv
// Directed bench for the ping-pong exchange buffer (DATA_W=8, ADDR_W=8,
// AUTO_COMMIT=1). Inputs change 1 ns after a rising edge; outputs are
// sampled at that same point, i.e. after the edge they depend on settled.
module tb_qoi_pingpong_buffer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  qoi_pingpong_buffer_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  qoi_pingpong_buffer #(.DATA_W(8), .ADDR_W(8), .AUTO_COMMIT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_cs = 1'b0; bus.a_we = 1'b0; bus.a_commit = 1'b0; bus.a_release = 1'b0;
    bus.b_cs = 1'b0; bus.b_we = 1'b0; bus.b_commit = 1'b0; bus.b_release = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.a_addr = 8'h00; bus.a_wdata = 8'h00; bus.b_addr = 8'h00; bus.b_wdata = 8'h00;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (bus.a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_a_in_ready got=%b exp=1", bus.a_in_ready); end
    total++; if (bus.b_out_ready !== 1'b1) begin bad++; $display("FAIL reset_b_out_ready got=%b exp=1", bus.b_out_ready); end
    total++; if ({bus.a_out_valid, bus.b_in_valid, bus.a_flag_o, bus.a_ovf, bus.b_ovf} !== 5'b00000) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.a_out_valid, bus.b_in_valid, bus.a_flag_o, bus.a_ovf, bus.b_ovf});
    end
    total++; if ({bus.a_rdata, bus.b_rdata} !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", {bus.a_rdata, bus.b_rdata}); end
  endtask

  task automatic test_ingress_fill();
    int flags;
    flags = 0;
    for (int i = 0; i < 256; i++) begin
      bus.a_cs = 1'b1; bus.a_we = 1'b1; bus.a_addr = i[7:0]; bus.a_wdata = i[7:0];
      tick();
      if (bus.a_flag_o === 1'b1) flags++;
    end
    idle();
    tick();
    total++; if (flags !== 1) begin bad++; $display("FAIL fill_flag_pulses got=%0d exp=1", flags); end
    total++; if (bus.a_flag_o !== 1'b0) begin bad++; $display("FAIL fill_flag_cleared got=%b exp=0", bus.a_flag_o); end
    total++; if (bus.b_in_valid !== 1'b1) begin bad++; $display("FAIL fill_b_in_valid got=%b exp=1", bus.b_in_valid); end
    total++; if (bus.a_in_ready !== 1'b1) begin bad++; $display("FAIL fill_a_in_ready got=%b exp=1", bus.a_in_ready); end
    bus.b_cs = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h10;
    tick();
    idle();
    total++; if (bus.b_rdata !== 8'h10) begin bad++; $display("FAIL fill_read_10 got=%h exp=10", bus.b_rdata); end
    tick();
    total++; if (bus.b_rdata !== 8'h10) begin bad++; $display("FAIL fill_rdata_hold got=%h exp=10", bus.b_rdata); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 256; i++) begin
      bus.a_cs = 1'b1; bus.a_we = 1'b1; bus.a_addr = i[7:0]; bus.a_wdata = i[7:0] ^ 8'hFF;
      tick();
    end
    idle();
    total++; if (bus.a_in_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready_low got=%b exp=0", bus.a_in_ready); end
    total++; if (bus.a_ovf !== 1'b0) begin bad++; $display("FAIL ovf_not_yet got=%b exp=0", bus.a_ovf); end
    bus.a_cs = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'h05; bus.a_wdata = 8'h77;
    tick();
    idle();
    total++; if (bus.a_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.a_ovf); end
    bus.b_release = 1'b1;
    tick();
    idle();
    total++; if ({bus.a_in_ready, bus.b_in_valid} !== 2'b11) begin bad++; $display("FAIL ovf_after_release got=%b exp=11", {bus.a_in_ready, bus.b_in_valid}); end
    bus.b_cs = 1'b1; bus.b_addr = 8'h05;
    tick();
    total++; if (bus.b_rdata !== 8'hFA) begin bad++; $display("FAIL ovf_bank1_addr5 got=%h exp=fa", bus.b_rdata); end
    bus.b_addr = 8'h10;
    tick();
    idle();
    total++; if (bus.b_rdata !== 8'hEF) begin bad++; $display("FAIL ovf_bank1_addr10 got=%h exp=ef", bus.b_rdata); end
    bus.b_release = 1'b1;
    tick();
    idle();
    total++; if ({bus.a_in_ready, bus.b_in_valid, bus.a_ovf} !== 3'b101) begin bad++; $display("FAIL ovf_drained got=%b exp=101", {bus.a_in_ready, bus.b_in_valid, bus.a_ovf}); end
  endtask

  task automatic test_explicit_commit();
    bus.a_cs = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'h00; bus.a_wdata = 8'h3C; bus.a_commit = 1'b1;
    tick();
    idle();
    total++; if ({bus.a_flag_o, bus.b_in_valid} !== 2'b11) begin bad++; $display("FAIL commit_flag_valid got=%b exp=11", {bus.a_flag_o, bus.b_in_valid}); end
    bus.b_cs = 1'b1; bus.b_addr = 8'h00;
    tick();
    idle();
    total++; if (bus.a_flag_o !== 1'b0) begin bad++; $display("FAIL commit_flag_one_cycle got=%b exp=0", bus.a_flag_o); end
    total++; if (bus.b_rdata !== 8'h3C) begin bad++; $display("FAIL commit_read got=%h exp=3c", bus.b_rdata); end
    bus.b_release = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_egress();
    bus.b_cs = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h03; bus.b_wdata = 8'hA5;
    tick();
    idle();
    total++; if (bus.a_out_valid !== 1'b0) begin bad++; $display("FAIL egr_uncommitted got=%b exp=0", bus.a_out_valid); end
    bus.b_commit = 1'b1;
    tick();
    idle();
    total++; if ({bus.a_out_valid, bus.b_out_ready} !== 2'b11) begin bad++; $display("FAIL egr_committed got=%b exp=11", {bus.a_out_valid, bus.b_out_ready}); end
    bus.a_cs = 1'b1; bus.a_we = 1'b0; bus.a_addr = 8'h03;
    tick();
    idle();
    total++; if (bus.a_rdata !== 8'hA5) begin bad++; $display("FAIL egr_read got=%h exp=a5", bus.a_rdata); end
    bus.a_release = 1'b1;
    tick();
    idle();
    total++; if (bus.a_out_valid !== 1'b0) begin bad++; $display("FAIL egr_released got=%b exp=0", bus.a_out_valid); end
  endtask

  task automatic test_empty_paths();
    bus.a_cs = 1'b1; bus.a_we = 1'b0; bus.a_addr = 8'h03;
    tick();
    idle();
    total++; if (bus.a_rdata !== 8'h00) begin bad++; $display("FAIL empty_read_zero got=%h exp=00", bus.a_rdata); end
    bus.a_release = 1'b1; bus.b_release = 1'b1;
    tick();
    idle();
    total++; if ({bus.a_out_valid, bus.b_out_ready, bus.b_in_valid, bus.a_in_ready} !== 4'b0101) begin
      bad++; $display("FAIL empty_release_ignored got=%b exp=0101", {bus.a_out_valid, bus.b_out_ready, bus.b_in_valid, bus.a_in_ready});
    end
  endtask

  task automatic test_back_to_back();
    // Egress is empty with wp=1, rp=1; walk it to full=01, wp=1, rp=0
    bus.b_commit = 1'b1;
    tick();
    idle();
    bus.a_release = 1'b1;
    tick();
    idle();
    bus.b_cs = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h07; bus.b_wdata = 8'h5A; bus.b_commit = 1'b1;
    tick();
    idle();
    total++; if ({bus.a_out_valid, bus.b_out_ready} !== 2'b11) begin bad++; $display("FAIL b2b_full01 got=%b exp=11", {bus.a_out_valid, bus.b_out_ready}); end
    // Commit bank 1 and release bank 0 in the same cycle
    bus.b_cs = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h07; bus.b_wdata = 8'hC3; bus.b_commit = 1'b1; bus.a_release = 1'b1;
    tick();
    idle();
    total++; if ({bus.a_out_valid, bus.b_out_ready} !== 2'b11) begin bad++; $display("FAIL b2b_full10 got=%b exp=11", {bus.a_out_valid, bus.b_out_ready}); end
    bus.a_cs = 1'b1; bus.a_we = 1'b0; bus.a_addr = 8'h07;
    tick();
    idle();
    total++; if (bus.a_rdata !== 8'hC3) begin bad++; $display("FAIL b2b_read_bank1 got=%h exp=c3", bus.a_rdata); end
    // Commit bank 0 with no new writes: old contents stay
    bus.b_commit = 1'b1;
    tick();
    idle();
    total++; if (bus.b_out_ready !== 1'b0) begin bad++; $display("FAIL b2b_full11 got=%b exp=0", bus.b_out_ready); end
    bus.b_cs = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h02; bus.b_wdata = 8'h11;
    tick();
    idle();
    total++; if (bus.b_ovf !== 1'b1) begin bad++; $display("FAIL b2b_b_ovf got=%b exp=1", bus.b_ovf); end
    bus.b_commit = 1'b1;
    tick();
    idle();
    bus.a_release = 1'b1;
    tick();
    idle();
    total++; if ({bus.a_out_valid, bus.b_out_ready} !== 2'b11) begin bad++; $display("FAIL b2b_commit_on_full got=%b exp=11", {bus.a_out_valid, bus.b_out_ready}); end
    bus.a_cs = 1'b1; bus.a_we = 1'b0; bus.a_addr = 8'h07;
    tick();
    idle();
    total++; if (bus.a_rdata !== 8'h5A) begin bad++; $display("FAIL b2b_old_contents got=%h exp=5a", bus.a_rdata); end
    bus.a_release = 1'b1;
    tick();
    idle();
    total++; if (bus.a_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", bus.a_out_valid); end
  endtask

  task automatic test_async_reset();
    bus.a_commit = 1'b1;
    tick();
    tick();
    idle();
    total++; if ({bus.b_in_valid, bus.a_in_ready} !== 2'b10) begin bad++; $display("FAIL arst_pre_full11 got=%b exp=10", {bus.b_in_valid, bus.a_in_ready}); end
    bus.a_cs = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'h09; bus.a_wdata = 8'h99;
    bus.b_cs = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h10;
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    total++; if ({bus.a_in_ready, bus.b_out_ready, bus.a_out_valid, bus.b_in_valid} !== 4'b1100) begin
      bad++; $display("FAIL arst_ready_valid got=%b exp=1100", {bus.a_in_ready, bus.b_out_ready, bus.a_out_valid, bus.b_in_valid});
    end
    total++; if ({bus.a_flag_o, bus.a_ovf, bus.b_ovf} !== 3'b000) begin bad++; $display("FAIL arst_flags got=%b exp=000", {bus.a_flag_o, bus.a_ovf, bus.b_ovf}); end
    total++; if ({bus.a_rdata, bus.b_rdata} !== 16'h0000) begin bad++; $display("FAIL arst_rdata got=%h exp=0000", {bus.a_rdata, bus.b_rdata}); end
    idle();
    tick();
    rst = 1'b0;
    tick();
    total++; if ({bus.a_in_ready, bus.b_in_valid} !== 2'b10) begin bad++; $display("FAIL arst_after got=%b exp=10", {bus.a_in_ready, bus.b_in_valid}); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    test_reset();
    test_ingress_fill();
    test_overflow();
    test_explicit_commit();
    test_egress();
    test_empty_paths();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
